us_timming_req_driver: RTL and testbench



---
 rtl/us_timming_req_driver.sv | 119 +++++++++++
 tb/tb_us_timming_req_driver.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/us_timming_req_driver.sv
// Edge-triggered FIFO drain: reads a latched number of entries and forwards them as a valid-qualified flow.
// Flow is valid 2 cycles after each rd_en; an empty FIFO stalls reads indefinitely; done pulses once the pipe drains.
module us_timming_req_driver #(
   parameter int DATA_W = 128,
   parameter int CNT_W  = 12
) (
   input  logic              sys_clk_i,
   input  logic              rst_n_i,
   input  logic              transmit_start_trigger_i,
   output logic              us_timming_rd_en_o,
   input  logic [DATA_W-1:0] us_timming_dout_i,
   input  logic              us_timming_empty_i,
   input  logic [CNT_W-1:0]  us_timming_cache_count_i,
   output logic              transmit_done_pluse_o,
   output logic              us_timming_flow_vld_o,
   output logic [DATA_W-1:0] us_timming_flow_o
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_trig;
   logic              r_trig_d1;
   logic              r_armed;
   logic              w_start;
   logic [CNT_W-1:0]  r_target;
   logic [CNT_W-1:0]  r_rd_cnt;
   logic              w_rd_en;
   logic              w_done;
   logic              r_rd_en_d1;
   logic              r_flow_vld;
   logic [DATA_W-1:0] r_flow;

   // r_armed blocks a trigger that is already high when reset releases from looking like a fresh edge.
   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_trig    <= 1'b0;
         r_trig_d1 <= 1'b0;
         r_armed   <= 1'b0;
      end else begin
         r_trig    <= transmit_start_trigger_i;
         r_trig_d1 <= r_trig;
         r_armed   <= r_armed | ~transmit_start_trigger_i;
      end
   end

   assign w_start = r_trig & ~r_trig_d1 & r_armed;

   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rd_en     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_state_nxt = (us_timming_cache_count_i == '0) ? DONE : READ;
            end
         end
         READ: begin
            w_rd_en = ~us_timming_empty_i & (r_rd_cnt < r_target);
            if (w_rd_en && (r_rd_cnt == r_target - CNT_W'(1))) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (!r_rd_en_d1 && !r_flow_vld) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Target is captured only on the start edge so later count changes cannot disturb a transfer.
   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_target <= '0;
         r_rd_cnt <= '0;
      end else if (r_state == IDLE && w_start) begin
         r_target <= us_timming_cache_count_i;
         r_rd_cnt <= '0;
      end else if (w_rd_en) begin
         r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_rd_en_d1 <= 1'b0;
         r_flow_vld <= 1'b0;
         r_flow     <= '0;
      end else begin
         r_rd_en_d1 <= w_rd_en;
         r_flow_vld <= r_rd_en_d1;
         if (r_rd_en_d1) begin
            r_flow <= us_timming_dout_i;
         end
      end
   end

   assign us_timming_rd_en_o    = w_rd_en;
   assign transmit_done_pluse_o = w_done;
   assign us_timming_flow_vld_o = r_flow_vld;
   assign us_timming_flow_o     = r_flow;

endmodule

// File: tb/tb_us_timming_req_driver.sv
// Directed bench for us_timming_req_driver: a pattern FIFO model, a negedge monitor, and linear checked steps.
// Inputs change 1 time unit after the rising edge; outputs are observed on the falling edge.
module tb_us_timming_req_driver;

   localparam int DATA_W = 128;
   localparam int CNT_W  = 12;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              trig;
   logic              rd_en;
   logic [DATA_W-1:0] dout = '0;
   logic              empty;
   logic [CNT_W-1:0]  count;
   logic              done;
   logic              vld;
   logic [DATA_W-1:0] flow;

   us_timming_req_driver #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .sys_clk_i                (clk),
      .rst_n_i                  (rst_n),
      .transmit_start_trigger_i (trig),
      .us_timming_rd_en_o       (rd_en),
      .us_timming_dout_i        (dout),
      .us_timming_empty_i       (empty),
      .us_timming_cache_count_i (count),
      .transmit_done_pluse_o    (done),
      .us_timming_flow_vld_o    (vld),
      .us_timming_flow_o        (flow)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] pat(input int unsigned i);
      pat = {i ^ 32'hDEAD_BEEF, i + 32'h0000_1000, ~i, i};
   endfunction

   // FIFO model: each entry is a function of its read index, so order is checkable.
   int unsigned rd_idx = 0;
   bit          pop    = 1'b0;
   always @(posedge clk) begin
      if (pop) begin
         dout   <= pat(rd_idx);
         rd_idx <= rd_idx + 1;
      end
   end

   int              t0;
   int unsigned     base;
   int              m_rd, m_run, m_maxrun, m_first_rd, m_first_vld, m_done, m_done_at;
   int              m_viol = 0;
   logic [127:0]    m_q[$];

   always @(negedge clk) begin
      pop = rst_n && rd_en;
      if (rst_n) begin
         if (rd_en) begin
            m_rd++;
            if (m_rd == 1) m_first_rd = cyc - t0;
            m_run++;
            if (m_run > m_maxrun) m_maxrun = m_run;
            if (empty) m_viol++;
         end else begin
            m_run = 0;
         end
         if (vld) begin
            if (m_q.size() == 0) m_first_vld = cyc - t0;
            m_q.push_back(flow);
         end
         if (done) begin
            m_done++;
            m_done_at = cyc - t0;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_mon();
      m_rd = 0; m_run = 0; m_maxrun = 0; m_first_rd = -1; m_first_vld = -1;
      m_done = 0; m_done_at = -1;
      m_q.delete();
      t0   = cyc;
      base = rd_idx;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_data(input string tag, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         if (i >= m_q.size() || m_q[i] !== pat(base + i)) bad++;
      end
      chk(tag, bad, 0);
   endtask

   task automatic rearm();
      trig = 1'b0;
      step(3);
      clear_mon();
   endtask

   initial begin
      rst_n = 1'b0; trig = 1'b0; empty = 1'b0; count = '0;
      clear_mon();
      step(3);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_done", done, 0);
      chk("rst_vld", vld, 0);
      chk("rst_flow", flow, 0);
      rst_n = 1'b1;
      step(2);

      // 12 reads, trigger held high afterwards
      clear_mon();
      count = 12; trig = 1'b1;
      step(25);
      chk("c12_rd", m_rd, 12);
      chk("c12_first_rd", m_first_rd, 2);
      chk("c12_run", m_maxrun, 12);
      chk("c12_vld", m_q.size(), 12);
      chk("c12_first_vld", m_first_vld, 4);
      chk_data("c12_data", 12);
      chk("c12_done", m_done, 1);
      chk("c12_done_at", m_done_at, 17);
      count = 7;
      step(20);
      chk("c12_hold_rd", m_rd, 12);
      chk("c12_hold_done", m_done, 1);

      // zero count goes straight to done
      rearm();
      count = 0; trig = 1'b1;
      step(10);
      chk("c0_rd", m_rd, 0);
      chk("c0_vld", m_q.size(), 0);
      chk("c0_done", m_done, 1);
      chk("c0_done_at", m_done_at, 2);

      // empty high on even offsets from the edge
      rearm();
      count = 4; trig = 1'b1; empty = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         step(1);
         empty = (k % 2 == 0);
      end
      empty = 1'b0;
      step(5);
      chk("c4e_rd", m_rd, 4);
      chk("c4e_first_rd", m_first_rd, 3);
      chk("c4e_run", m_maxrun, 1);
      chk("c4e_vld", m_q.size(), 4);
      chk_data("c4e_data", 4);
      chk("c4e_done", m_done, 1);
      chk("c4e_done_at", m_done_at, 13);

      // second edge and count change while reading are ignored
      rearm();
      count = 8; trig = 1'b1;
      step(3);
      trig = 1'b0;
      step(2);
      trig = 1'b1; count = 3;
      step(30);
      chk("c8_rd", m_rd, 8);
      chk("c8_vld", m_q.size(), 8);
      chk_data("c8_data", 8);
      chk("c8_done", m_done, 1);
      chk("c8_done_at", m_done_at, 13);

      // reset in the middle of READ
      rearm();
      count = 10; trig = 1'b1;
      step(5);
      chk("rmid_rd_en_pre", rd_en, 1);
      chk("rmid_vld_pre", vld, 1);
      rst_n = 1'b0;
      #1;
      chk("rmid_rd_en", rd_en, 0);
      chk("rmid_vld", vld, 0);
      chk("rmid_flow", flow, 0);
      chk("rmid_done", done, 0);
      step(3);
      rst_n = 1'b1;
      step(15);
      chk("rmid_done_cnt", m_done, 0);
      clear_mon();
      step(10);
      chk("rmid_held_rd", m_rd, 0);
      chk("rmid_held_done", m_done, 0);
      rearm();
      count = 5; trig = 1'b1;
      step(15);
      chk("rpost_rd", m_rd, 5);
      chk_data("rpost_data", 5);
      chk("rpost_done", m_done, 1);
      chk("rpost_done_at", m_done_at, 10);

      // single entry
      rearm();
      count = 1; trig = 1'b1;
      step(12);
      chk("c1_rd", m_rd, 1);
      chk("c1_first_rd", m_first_rd, 2);
      chk("c1_vld", m_q.size(), 1);
      chk("c1_first_vld", m_first_vld, 4);
      chk_data("c1_data", 1);
      chk("c1_done_at", m_done_at, 6);

      // full-scale count
      rearm();
      count = 4095; trig = 1'b1;
      step(4110);
      chk("cmax_rd", m_rd, 4095);
      chk("cmax_run", m_maxrun, 4095);
      chk("cmax_vld", m_q.size(), 4095);
      chk_data("cmax_data", 4095);
      chk("cmax_done", m_done, 1);
      chk("cmax_done_at", m_done_at, 4100);

      chk("rd_while_empty", m_viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
